// File: rtl/div_share_ctrl_if.sv
// Requester/response bundle for the shared divider scheduler.
//   req_valid/req_ready        per-requester handshake (one bit per requester)
//   req_dividend/req_divisor   packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready        single response handshake
//   rsp_id                     index of the requester that owns the response
//   rsp_quotient/rsp_remainder divider results
//   rsp_zero_err               divisor was zero; quotient/remainder are don't-care
// master: requester/consumer side; slave: the scheduler.
interface div_share_ctrl_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_quotient;
  logic [WIDTH-1:0]       rsp_remainder;
  logic                   rsp_zero_err;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_zero_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_zero_err
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin scheduler sharing one sequential divider between N_REQ requesters.
// Accepts one request at a time, pulses div_start for one cycle, waits for the
// divider (including the divide-by-zero shortcut) and returns the tagged result
// on a single backpressured response channel.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             requester/response bundle (slave side)
//   busy            high whenever the scheduler is not idle
//   div_start       one-cycle start pulse to the divider
//   div_dividend    registered operand to the divider
//   div_divisor     registered operand to the divider
//   div_quotient    divider quotient
//   div_remainder   divider remainder
//   div_zero_err    divider divide-by-zero flag
//   div_valid       divider result valid (only while divider idle and not started)
module div_share_ctrl #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  div_share_ctrl_if.slave  bus,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_zero_err,
  input  logic             div_valid
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             accept;
  logic             capture;
  logic [N_REQ-1:0] ready_c;
  logic [WIDTH-1:0] dividend_q, divisor_q, quot_q, rem_q;
  logic             zero_err_q, rsp_valid_q, start_q, busy_q;
  logic [WIDTH-1:0] dvd_arr [N_REQ];
  logic [WIDTH-1:0] dvs_arr [N_REQ];

  // Unpack the per-requester operand lanes.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign dvd_arr[gi] = bus.req_dividend[gi*WIDTH +: WIDTH];
    assign dvs_arr[gi] = bus.req_divisor[gi*WIDTH +: WIDTH];
  end

  // Rotating-priority search starting just after the last grant.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    ready_c = '0;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          ready_c[grant] = 1'b1;
          accept         = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // div_valid seen in ISSUE is stale; only trust it from WAIT on.
        if (div_valid) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      zero_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_d == RESP);
      start_q     <= (state_d == ISSUE);
      busy_q      <= (state_d != IDLE);
      if (accept) begin
        rr_ptr_q   <= grant;
        id_q       <= grant;
        dividend_q <= dvd_arr[grant];
        divisor_q  <= dvs_arr[grant];
      end
      if (capture) begin
        quot_q     <= div_quotient;
        rem_q      <= div_remainder;
        zero_err_q <= div_zero_err;
      end
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = id_q;
  assign bus.rsp_quotient  = quot_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_zero_err  = zero_err_q;
  assign busy              = busy_q;
  assign div_start         = start_q;
  assign div_dividend      = dividend_q;
  assign div_divisor       = divisor_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: behavioural divider, request driver with a
// round-robin arbitration model, scoreboard queue and a response monitor.
module tb_div_share_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int DRAIN_LIMIT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_share_ctrl_if #(.N_REQ(N), .WIDTH(W)) bus ();

  logic         busy, div_start, div_zero_err, div_valid;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;

  div_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_zero_err(div_zero_err), .div_valid(div_valid)
  );

  typedef struct { int a; int b; } op_t;
  typedef struct { int id; int q; int r; int z; int due; int acc; } exp_t;

  op_t  pend [N][$];
  exp_t exp_q[$];
  int   lat_q[$];
  int   grant_log[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   outstanding = 0;
  int   model_ptr = N - 1;
  int   bp_mode = 0;
  int   force_lat = -1;
  int   last_id = -1, last_q = -1, last_r = -1, last_z = -1, last_lat = -1;

  function automatic void chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic int pend_count();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend[i].size();
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: busy for a chosen number of cycles, zero divisor stays idle.
  int           busy_cnt = 0;
  int           l_pick;
  logic [W-1:0] op_a, op_b;
  assign div_valid = (busy_cnt == 0) && !div_start;
  always @(posedge clk) begin
    if (rst) begin
      busy_cnt      <= 0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_zero_err  <= 1'b0;
    end else if (busy_cnt == 0) begin
      if (div_start) begin
        l_pick = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        if (div_divisor == 0) begin
          div_zero_err  <= 1'b1;
          div_quotient  <= '1;
          div_remainder <= div_dividend;
        end else begin
          div_zero_err <= 1'b0;
          busy_cnt     <= l_pick;
          op_a         <= div_dividend;
          op_b         <= div_divisor;
        end
      end
    end else begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        div_quotient  <= op_a / op_b;
        div_remainder <= op_a % op_b;
      end
    end
  end

  // Request driver and arbitration model.
  logic [N-1:0]   rv;
  logic [N*W-1:0] dd, ds;
  always @(negedge clk) begin
    int g, gi, l, exp_ready;
    op_t  o;
    exp_t e;
    rv = '0; dd = '0; ds = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0) begin
        rv[i] = 1'b1;
        dd[i*W +: W] = W'(pend[i][0].a);
        ds[i*W +: W] = W'(pend[i][0].b);
      end
    end
    bus.req_valid    = rv;
    bus.req_dividend = dd;
    bus.req_divisor  = ds;
    case (bp_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = 1'b0;
      default: bus.rsp_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (model_ptr + k) % N;
      if (g < 0 && rv[idx]) g = idx;
    end
    exp_ready = 0;
    if (!rst && !outstanding && g >= 0) exp_ready = 1 << g;
    chk("req_ready", int'(bus.req_ready), exp_ready);
    gi = -1;
    for (int i = 0; i < N; i++) if (gi < 0 && bus.req_ready[i]) gi = i;
    if (!rst && gi >= 0 && rv[gi]) begin
      o = pend[gi].pop_front();
      l = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
      e.id  = gi;
      e.z   = (o.b == 0) ? 1 : 0;
      e.q   = (o.b == 0) ? 0 : o.a / o.b;
      e.r   = (o.b == 0) ? 0 : o.a % o.b;
      e.acc = cyc;
      e.due = cyc + 3 + ((o.b == 0) ? 0 : l);
      exp_q.push_back(e);
      lat_q.push_back(l);
      outstanding = 1;
      model_ptr   = gi;
      grant_log.push_back(gi);
    end
  end

  // Response monitor / scoreboard.
  bit pv = 0, pr = 0;
  int s_id, s_q, s_r, s_z;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(bus.rsp_valid), 1);
        chk("hold_id", int'(bus.rsp_id), s_id);
        chk("hold_quotient", int'(bus.rsp_quotient), s_q);
        chk("hold_remainder", int'(bus.rsp_remainder), s_r);
        chk("hold_zero_err", int'(bus.rsp_zero_err), s_z);
      end
      if (bus.rsp_valid) begin
        chk("start_in_resp", int'(div_start), 0);
        if (!pv && exp_q.size() > 0) begin
          chk("latency", cyc, exp_q[0].due);
          last_lat = cyc - exp_q[0].acc;
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", int'(bus.rsp_id), e.id);
            chk("rsp_zero_err", int'(bus.rsp_zero_err), e.z);
            if (e.z == 0) begin
              chk("rsp_quotient", int'(bus.rsp_quotient), e.q);
              chk("rsp_remainder", int'(bus.rsp_remainder), e.r);
            end
            outstanding = 0;
          end
          last_id = int'(bus.rsp_id);
          last_q  = int'(bus.rsp_quotient);
          last_r  = int'(bus.rsp_remainder);
          last_z  = int'(bus.rsp_zero_err);
        end
      end
      pv   = bus.rsp_valid;
      pr   = bus.rsp_ready;
      s_id = int'(bus.rsp_id);
      s_q  = int'(bus.rsp_quotient);
      s_r  = int'(bus.rsp_remainder);
      s_z  = int'(bus.rsp_zero_err);
    end
  end

  task automatic enq(input int id, input int a, input int b);
    op_t o;
    o.a = a;
    o.b = b;
    pend[id].push_back(o);
  endtask

  task automatic drain();
    int n = 0;
    while ((pend_count() > 0 || exp_q.size() > 0 || outstanding) && n < DRAIN_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n >= DRAIN_LIMIT) ? 1 : 0, 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i].delete();
    exp_q.delete();
    lat_q.delete();
    outstanding = 0;
    model_ptr   = N - 1;
    @(posedge clk); #1;
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_div_start", int'(div_start), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n;
    // Reset state; requester 0 already asserting must not be accepted during reset.
    @(posedge clk); #1;
    enq(0, 200, 7);
    @(posedge clk); #1;
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_div_start", int'(div_start), 0);
    chk("reset_rsp_id", int'(bus.rsp_id), 0);
    chk("reset_quotient", int'(bus.rsp_quotient), 0);
    chk("reset_remainder", int'(bus.rsp_remainder), 0);
    chk("reset_zero_err", int'(bus.rsp_zero_err), 0);
    chk("reset_div_dividend", int'(div_dividend), 0);
    chk("reset_div_divisor", int'(div_divisor), 0);
    rst = 1'b0;

    // Single request 200/7.
    drain();
    chk("t1_id", last_id, 0);
    chk("t1_quotient", last_q, 28);
    chk("t1_remainder", last_r, 4);
    chk("t1_zero_err", last_z, 0);

    // Divide by zero from requester 1.
    enq(1, 200, 0);
    drain();
    chk("t2_id", last_id, 1);
    chk("t2_zero_err", last_z, 1);
    chk("t2_latency", last_lat, 3);

    // Round robin with all four requesters asserting.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) enq(i, 100 + i, 3);
    enq(0, 100, 3);
    drain();
    chk("t3_grants", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t3_order", grant_log[i], exp_order[i]);

    // Backpressure held for 10 cycles in RESP.
    enq(0, 77, 5);
    enq(3, 50, 6);
    bp_mode = 1;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_rsp_seen", (n >= 100) ? 1 : 0, 0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t4_valid_held", int'(bus.rsp_valid), 1);
      chk("t4_req_ready", int'(bus.req_ready), 0);
      chk("t4_div_start", int'(div_start), 0);
      chk("t4_busy", int'(busy), 1);
    end
    bp_mode = 0;
    drain();
    chk("t4_last_id", last_id, 0);
    chk("t4_last_quotient", last_q, 15);

    // Reset while the divider is busy; the job is abandoned.
    force_lat = 8;
    enq(0, 255, 1);
    n = 0;
    while (!div_start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_start_seen", (n >= 50) ? 1 : 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset();
    force_lat = -1;
    enq(2, 9, 2);
    drain();
    chk("t5_id", last_id, 2);
    chk("t5_quotient", last_q, 4);
    chk("t5_remainder", last_r, 1);

    // Operand extremes.
    enq(0, 255, 255);
    enq(1, 0, 5);
    enq(2, 5, 255);
    drain();
    chk("t6_last_quotient", last_q, 0);
    chk("t6_last_remainder", last_r, 5);

    // Random traffic with random backpressure.
    bp_mode = 2;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0)
        enq(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
    end
    drain();
    bp_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
